binary_subtractor_seq: RTL and testbench



---
 rtl/binary_subtractor_seq.sv | 117 +++++++++++
 tb/tb_binary_subtractor_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/binary_subtractor_seq.sv
// binary_subtractor_seq
// Multi-cycle borrow-lookahead subtractor: D = A - B - bin (mod 2^WIDTH).
// One 4-bit slice is resolved per clock with a flattened generate/propagate
// borrow chain. The slice borrow-out is registered as the next slice's
// borrow-in. A valid/ready handshake is used on both the operand side and
// the result side.
module binary_subtractor_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             bout
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       r_state;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic [3:0] w_a_sl;
  logic [3:0] w_b_sl;
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_br;
  logic [3:0] w_diff;
  logic       w_last;

  // Select the current slice and resolve its borrows in lookahead form
  always_comb begin
    w_a_sl = r_a[4*r_k +: 4];
    w_b_sl = r_b[4*r_k +: 4];
    w_g    = ~w_a_sl & w_b_sl;
    w_p    = ~(w_a_sl ^ w_b_sl);
    w_br[0] = r_br;
    w_br[1] = w_g[0] | (w_p[0] & r_br);
    w_br[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_br);
    w_br[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
            | (w_p[2] & w_p[1] & w_p[0] & r_br);
    w_br[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
            | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_br);
    w_diff = w_a_sl ^ w_b_sl ^ w_br[3:0];
    w_last = (r_k == KW'(N - 1));
  end

  // Handshake FSM, operand capture and per-slice result accumulation
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every read in
    // this block sees the value from before the edge, whatever the statement order.
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_br    <= 1'b0;
      r_d     <= '0;
      r_bout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_br    <= bin;
            r_k     <= '0;
            r_d     <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_d[4*r_k +: 4] <= w_diff;
          r_br            <= w_br[4];
          if (w_last) begin
            r_bout  <= w_br[4];
            r_state <= DONE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Operand registers load only on accept
  always_ff @(posedge clk) begin
    // NOTE: the operand registers have no reset. They are always overwritten
    // on accept before they are read.
    if (r_state == IDLE && in_valid) begin
      r_a <= A;
      r_b <= B;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign D         = r_d;
  assign bout      = r_bout;

endmodule

// File: tb/tb_binary_subtractor_seq.sv
// Self-checking bench for binary_subtractor_seq (WIDTH = 16).
// Expected results come from plain modular arithmetic, not from the slice structure.
module tb_binary_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] D;
  logic        bout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    logic [15:0] d;
    logic        bo;
  } vec_t;

  vec_t vecs[7];

  binary_subtractor_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .bout      (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: unsigned modular subtraction and a plain magnitude compare
  function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b, input logic bi);
    int unsigned diff;
    logic        borrow;
    diff   = (int'(a) - int'(b) - int'(bi)) & 32'h0000_FFFF;
    borrow = (int'(a) < int'(b) + int'(bi));
    return {borrow, diff[15:0]};
  endfunction

  // One full transaction: accept, wait for the result, hold it for `stall`
  // cycles, then consume. With `bp` set, in_valid is pulsed during the stall
  // and the held result and handshake outputs are checked every cycle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                       input int stall, input bit bp,
                       output logic [15:0] d, output logic bo, output int lat);
    int w;
    w = 0;
    out_ready = 1'b0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    A = a; B = b; bin = bi; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A = 16'($urandom); B = 16'($urandom); bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    d  = D;
    bo = bout;
    for (int s = 0; s < stall; s++) begin
      if (bp) begin
        in_valid = 1'b1;
        A = 16'($urandom); B = 16'($urandom); bin = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      if (bp) begin
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_D_stable", 32'(D), 32'(d));
        check("bp_bout_stable", 32'(bout), 32'(bo));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("consume_in_ready", 32'(in_ready), 32'd1);
    check("consume_out_valid", 32'(out_valid), 32'd0);
  endtask

  logic [15:0] got_d;
  logic        got_bo;
  int          lat;
  logic [16:0] exp_r;
  logic [15:0] ra, rb;
  logic        rbi;

  initial begin
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vecs[2] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0};
    vecs[3] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_D", 32'(D), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bi, 0, 1'b0, got_d, got_bo, lat);
      check("vec_latency", 32'(lat), 32'd4);
      check("vec_D", 32'(got_d), 32'(vecs[i].d));
      check("vec_bout", 32'(got_bo), 32'(vecs[i].bo));
    end

    // Backpressure: six stalled cycles with in_valid pulses
    do_op(16'h0000, 16'h0001, 1'b0, 6, 1'b1, got_d, got_bo, lat);
    check("bp_D", 32'(got_d), 32'hFFFF);
    check("bp_bout", 32'(got_bo), 32'd1);

    // Reset while slice 2 is being processed
    @(negedge clk);
    A = 16'h1234; B = 16'h0234; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    check("midrun_rst_D", 32'(D), 32'd0);
    check("midrun_rst_bout", 32'(bout), 32'd0);
    rst_n = 1'b1;
    // Let the slot where a stale result would have appeared pass
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("midrun_no_out_valid", 32'(out_valid), 32'd0);
    end
    do_op(16'h8000, 16'h7FFF, 1'b1, 0, 1'b0, got_d, got_bo, lat);
    check("after_rst_latency", 32'(lat), 32'd4);
    check("after_rst_D", 32'(got_d), 32'h0000);
    check("after_rst_bout", 32'(got_bo), 32'd0);

    // Random operands with random result stalls
    for (int i = 0; i < 1000; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rbi = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      exp_r = ref_sub(ra, rb, rbi);
      do_op(ra, rb, rbi, int'($urandom_range(0, 3)), 1'b0, got_d, got_bo, lat);
      check("rnd_latency", 32'(lat), 32'd4);
      check("rnd_D", 32'(got_d), 32'(exp_r[15:0]));
      check("rnd_bout", 32'(got_bo), 32'(exp_r[16]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
